// File: rtl/fp_div_sqrt_arbiter_if.sv
// Handshake and datapath bundle between the FP divide/sqrt units, the arbiter
// and the shared iterative mantissa core.
interface fp_div_sqrt_arbiter_if #(
  parameter int DATA_WIDTH = 55
);
  // Requester side: a start is accepted in a cycle where start && ready; an
  // unaccepted start must be held. done stays high until the owner acks it.
  logic                  div_start;
  logic [DATA_WIDTH-1:0] div_dividend;
  logic [DATA_WIDTH-1:0] div_divisor;
  logic                  div_ready;
  logic                  div_done;
  logic                  div_ack;
  logic                  sqrt_start;
  logic [DATA_WIDTH-1:0] sqrt_radicand;
  logic                  sqrt_ready;
  logic                  sqrt_done;
  logic                  sqrt_ack;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH+1:0] remainder;
  logic                  core_start;
  logic                  core_is_sqrt;
  logic [DATA_WIDTH-1:0] core_a;
  logic [DATA_WIDTH-1:0] core_b;
  logic                  core_done;
  logic [DATA_WIDTH-1:0] core_result;
  logic [DATA_WIDTH+1:0] core_remainder;

  modport slave (
    input  div_start, div_dividend, div_divisor, div_ack,
    input  sqrt_start, sqrt_radicand, sqrt_ack,
    input  core_done, core_result, core_remainder,
    output div_ready, div_done, sqrt_ready, sqrt_done, result, remainder,
    output core_start, core_is_sqrt, core_a, core_b
  );

  modport master (
    output div_start, div_dividend, div_divisor, div_ack,
    output sqrt_start, sqrt_radicand, sqrt_ack,
    output core_done, core_result, core_remainder,
    input  div_ready, div_done, sqrt_ready, sqrt_done, result, remainder,
    input  core_start, core_is_sqrt, core_a, core_b
  );
endinterface

// File: rtl/fp_div_sqrt_arbiter.sv
// Round-robin arbiter sharing one iterative mantissa core between the FP
// divide unit (requester 0) and the FP square-root unit (requester 1).
module fp_div_sqrt_arbiter #(
  parameter int DATA_WIDTH = 55
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_div_sqrt_arbiter_if.slave  bus,
  output logic [1:0]            o_state,
  output logic                  o_owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_owner;
  logic                  r_rr_ptr;
  logic                  r_div_done;
  logic                  r_sqrt_done;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH+1:0] r_remainder;

  logic w_owner_ack;
  logic w_ready;
  logic w_grant;
  logic w_grant_sqrt;

  always_comb begin
    w_next_state = r_state;
    w_owner_ack  = r_owner ? bus.sqrt_ack : bus.div_ack;
    // A HOLD ack frees the core in the same cycle so the next op can launch.
    w_ready      = (r_state == S_IDLE) || ((r_state == S_HOLD) && w_owner_ack);
    w_grant      = w_ready && (bus.div_start || bus.sqrt_start);
    w_grant_sqrt = (bus.div_start && bus.sqrt_start) ? r_rr_ptr : bus.sqrt_start;
    case (r_state)
      S_IDLE: if (w_grant) w_next_state = S_BUSY;
      S_BUSY: if (bus.core_done) w_next_state = S_HOLD;
      S_HOLD: if (w_owner_ack) w_next_state = w_grant ? S_BUSY : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_div_done  <= 1'b0;
      r_sqrt_done <= 1'b0;
      r_result    <= '0;
      r_remainder <= '0;
    end else begin
      if (w_grant) begin
        r_owner  <= w_grant_sqrt;
        r_rr_ptr <= ~w_grant_sqrt;
      end
      if ((r_state == S_BUSY) && bus.core_done) begin
        r_result    <= bus.core_result;
        r_remainder <= bus.core_remainder;
        r_div_done  <= ~r_owner;
        r_sqrt_done <= r_owner;
      end else if ((r_state == S_HOLD) && w_owner_ack) begin
        r_div_done  <= 1'b0;
        r_sqrt_done <= 1'b0;
      end
    end
  end

  assign bus.div_ready    = w_ready;
  assign bus.sqrt_ready   = w_ready;
  assign bus.div_done     = r_div_done;
  assign bus.sqrt_done    = r_sqrt_done;
  assign bus.result       = r_result;
  assign bus.remainder    = r_remainder;
  assign bus.core_start   = w_grant;
  assign bus.core_is_sqrt = w_grant && w_grant_sqrt;
  assign bus.core_a       = !w_grant ? '0 : (w_grant_sqrt ? bus.sqrt_radicand : bus.div_dividend);
  assign bus.core_b       = (w_grant && !w_grant_sqrt) ? bus.div_divisor : '0;
  assign o_state          = r_state;
  assign o_owner          = r_owner;

endmodule

// File: tb/tb_fp_div_sqrt_arbiter.sv
// Bench for fp_div_sqrt_arbiter: a stub core with fixed latency plus
// scenario tasks that check launches, ownership, hold and reset behaviour.
module tb_fp_div_sqrt_arbiter;
  localparam int W = 55;
  localparam int CORE_LAT = 3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] st;
  logic       own;

  fp_div_sqrt_arbiter_if #(.DATA_WIDTH(W)) bus ();

  fp_div_sqrt_arbiter #(.DATA_WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (st),
    .o_owner (own)
  );

  always #5 clk = ~clk;

  // Stand-in core: fixed latency, easily predicted fake results.
  function automatic logic [W-1:0] core_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    return s ? ((a >> 1) ^ 55'h0F0F) : (a + b);
  endfunction

  function automatic logic [W+1:0] core_rem(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    return s ? {2'b10, ~a} : {2'b01, a ^ b};
  endfunction

  logic         m_busy, m_done, spur_done;
  int           m_cnt;
  logic [W-1:0] m_res;
  logic [W+1:0] m_rem;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) begin
      m_busy <= 1'b0;
    end else if (bus.core_start) begin
      m_busy <= 1'b1;
      m_cnt  <= CORE_LAT;
      m_res  <= core_res(bus.core_a, bus.core_b, bus.core_is_sqrt);
      m_rem  <= core_rem(bus.core_a, bus.core_b, bus.core_is_sqrt);
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign bus.core_done      = m_done | spur_done;
  assign bus.core_result    = spur_done ? 55'h7A_BCDE_F012_3456 : m_res;
  assign bus.core_remainder = spur_done ? 57'h1_2345_6789_ABCD : m_rem;

  logic [W-1:0] exp_q[$];
  logic [W+1:0] exp_rem_q[$];
  logic         exp_own_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] e_r;
  logic [W+1:0] e_m;
  logic         e_o;
  bit           to;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_q.push_back(core_res(a, s ? '0 : b, s));
    exp_rem_q.push_back(core_rem(a, s ? '0 : b, s));
    exp_own_q.push_back(s);
  endtask

  task automatic pop_exp;
    if (exp_q.size() > 0) begin
      e_r = exp_q.pop_front();
      e_m = exp_rem_q.pop_front();
      e_o = exp_own_q.pop_front();
    end else begin
      e_r = 'x; e_m = 'x; e_o = 1'bx;
    end
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step;
      if (bus.div_done || bus.sqrt_done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    n_checks++; if (st !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", st, ST_IDLE); end
    n_checks++; if ({bus.sqrt_done, bus.div_done} !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b want 00", {bus.sqrt_done, bus.div_done}); end
    n_checks++; if (bus.result !== '0 || bus.remainder !== '0) begin n_fail++; $display("FAIL reset_result: got %h/%h want 0/0", bus.result, bus.remainder); end
    n_checks++; if ({bus.sqrt_ready, bus.div_ready, bus.core_start} !== 3'b110) begin n_fail++; $display("FAIL reset_ready: got %b want 110", {bus.sqrt_ready, bus.div_ready, bus.core_start}); end
  endtask

  task automatic test_single_div;
    logic [W-1:0] a, b;
    a = 55'h20_0000_0000_0000;
    b = 55'h10_0000_0000_0000;
    bus.div_start = 1'b1; bus.div_dividend = a; bus.div_divisor = b;
    #1;
    n_checks++; if ({bus.core_start, bus.core_is_sqrt} !== 2'b10) begin n_fail++; $display("FAIL div_launch: got %b want 10", {bus.core_start, bus.core_is_sqrt}); end
    n_checks++; if (bus.core_a !== a || bus.core_b !== b) begin n_fail++; $display("FAIL div_operands: got %h/%h want %h/%h", bus.core_a, bus.core_b, a, b); end
    push_exp(a, b, 1'b0);
    step;
    bus.div_start = 1'b0;
    #1;
    n_checks++; if (bus.div_ready !== 1'b0 || st !== ST_BUSY) begin n_fail++; $display("FAIL div_busy: got ready=%b st=%0d want 0/%0d", bus.div_ready, st, ST_BUSY); end
    wait_done(to);
    pop_exp;
    n_checks++; if (to) begin n_fail++; $display("FAIL div_timeout: got no done want done"); end
    n_checks++; if (bus.result !== e_r || bus.remainder !== e_m) begin n_fail++; $display("FAIL div_result: got %h/%h want %h/%h", bus.result, bus.remainder, e_r, e_m); end
    n_checks++; if ({bus.sqrt_done, bus.div_done} !== 2'b01) begin n_fail++; $display("FAIL div_done_owner: got %b want 01", {bus.sqrt_done, bus.div_done}); end
    bus.div_ack = 1'b1;
    step;
    bus.div_ack = 1'b0;
    #1;
    n_checks++; if (st !== ST_IDLE || bus.div_done !== 1'b0) begin n_fail++; $display("FAIL div_ack_idle: got st=%0d done=%b want %0d/0", st, bus.div_done, ST_IDLE); end
  endtask

  task automatic test_both_start;
    logic [W-1:0] a, b, r;
    do_reset;
    a = W'($urandom()); b = W'($urandom()) | 55'h1; r = W'($urandom());
    bus.div_start = 1'b1; bus.div_dividend = a; bus.div_divisor = b;
    bus.sqrt_start = 1'b1; bus.sqrt_radicand = r;
    #1;
    n_checks++; if ({bus.core_start, bus.core_is_sqrt} !== 2'b10 || bus.core_a !== a) begin n_fail++; $display("FAIL both_first_grant: got %b a=%h want 10 a=%h", {bus.core_start, bus.core_is_sqrt}, bus.core_a, a); end
    push_exp(a, b, 1'b0);
    step;
    bus.div_start = 1'b0;
    wait_done(to);
    pop_exp;
    n_checks++; if (to || bus.result !== e_r || {bus.sqrt_done, bus.div_done} !== 2'b01) begin n_fail++; $display("FAIL both_div_result: got %h done=%b want %h done=01", bus.result, {bus.sqrt_done, bus.div_done}, e_r); end
    bus.div_ack = 1'b1;
    #1;
    n_checks++; if ({bus.core_start, bus.core_is_sqrt} !== 2'b11 || bus.core_b !== '0 || bus.core_a !== r) begin n_fail++; $display("FAIL both_sqrt_regrant: got %b a=%h b=%h want 11 a=%h b=0", {bus.core_start, bus.core_is_sqrt}, bus.core_a, bus.core_b, r); end
    push_exp(r, '0, 1'b1);
    step;
    bus.div_ack = 1'b0; bus.sqrt_start = 1'b0;
    #1;
    n_checks++; if (st !== ST_BUSY || bus.div_done !== 1'b0 || own !== 1'b1) begin n_fail++; $display("FAIL both_sqrt_busy: got st=%0d done=%b own=%b want %0d/0/1", st, bus.div_done, own, ST_BUSY); end
    wait_done(to);
    pop_exp;
    n_checks++; if (to || bus.result !== e_r || bus.remainder !== e_m || {bus.sqrt_done, bus.div_done} !== 2'b10) begin n_fail++; $display("FAIL both_sqrt_result: got %h/%h done=%b want %h/%h done=10", bus.result, bus.remainder, {bus.sqrt_done, bus.div_done}, e_r, e_m); end
    bus.sqrt_ack = 1'b1;
    step;
    bus.sqrt_ack = 1'b0;
  endtask

  task automatic test_alternate;
    logic s;
    bus.div_start = 1'b1; bus.div_dividend = W'($urandom()); bus.div_divisor = W'($urandom());
    bus.sqrt_start = 1'b1; bus.sqrt_radicand = W'($urandom());
    #1;
    for (int k = 0; k < 4; k++) begin
      s = k[0];
      n_checks++; if ({bus.core_start, bus.core_is_sqrt} !== {1'b1, s}) begin n_fail++; $display("FAIL alt_grant_%0d: got %b want %b", k, {bus.core_start, bus.core_is_sqrt}, {1'b1, s}); end
      push_exp(s ? bus.sqrt_radicand : bus.div_dividend, bus.div_divisor, s);
      step;
      bus.div_ack = 1'b0; bus.sqrt_ack = 1'b0;
      if (s) bus.sqrt_radicand = W'($urandom());
      else begin bus.div_dividend = W'($urandom()); bus.div_divisor = W'($urandom()); end
      if (k == 3) begin bus.div_start = 1'b0; bus.sqrt_start = 1'b0; end
      wait_done(to);
      pop_exp;
      n_checks++; if (to || bus.result !== e_r || {bus.sqrt_done, bus.div_done} !== {e_o, ~e_o}) begin n_fail++; $display("FAIL alt_result_%0d: got %h done=%b want %h done=%b", k, bus.result, {bus.sqrt_done, bus.div_done}, e_r, {e_o, ~e_o}); end
      if (s) bus.sqrt_ack = 1'b1;
      else   bus.div_ack = 1'b1;
      #1;
    end
    step;
    bus.div_ack = 1'b0; bus.sqrt_ack = 1'b0;
    #1;
    n_checks++; if (st !== ST_IDLE) begin n_fail++; $display("FAIL alt_final_idle: got %0d want %0d", st, ST_IDLE); end
  endtask

  task automatic test_nonowner_ack;
    logic [W-1:0] r;
    r = W'($urandom());
    bus.sqrt_start = 1'b1; bus.sqrt_radicand = r;
    #1;
    push_exp(r, '0, 1'b1);
    step;
    bus.sqrt_start = 1'b0;
    wait_done(to);
    pop_exp;
    n_checks++; if (to || bus.result !== e_r || {bus.sqrt_done, bus.div_done} !== 2'b10) begin n_fail++; $display("FAIL nonown_sqrt_result: got %h done=%b want %h done=10", bus.result, {bus.sqrt_done, bus.div_done}, e_r); end
    bus.div_ack = 1'b1;
    #1;
    n_checks++; if (bus.sqrt_ready !== 1'b0) begin n_fail++; $display("FAIL nonown_ready: got %b want 0", bus.sqrt_ready); end
    step;
    bus.div_ack = 1'b0;
    #1;
    n_checks++; if (st !== ST_HOLD || bus.sqrt_done !== 1'b1 || bus.result !== e_r) begin n_fail++; $display("FAIL nonown_hold: got st=%0d done=%b res=%h want %0d/1/%h", st, bus.sqrt_done, bus.result, ST_HOLD, e_r); end
    bus.sqrt_ack = 1'b1;
    step;
    bus.sqrt_ack = 1'b0;
    #1;
    n_checks++; if (st !== ST_IDLE || bus.sqrt_done !== 1'b0) begin n_fail++; $display("FAIL nonown_ack_idle: got st=%0d done=%b want %0d/0", st, bus.sqrt_done, ST_IDLE); end
  endtask

  task automatic test_stall_hold;
    logic [W-1:0] a, b;
    int bad;
    a = W'($urandom()); b = W'($urandom());
    bus.div_start = 1'b1; bus.div_dividend = a; bus.div_divisor = b;
    #1;
    push_exp(a, b, 1'b0);
    step;
    bus.div_start = 1'b0;
    wait_done(to);
    pop_exp;
    n_checks++; if (to) begin n_fail++; $display("FAIL stall_timeout: got no done want done"); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      spur_done = (i == 4);
      step;
      spur_done = 1'b0;
      if (bus.div_done !== 1'b1 || bus.result !== e_r || bus.remainder !== e_m || st !== ST_HOLD) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_stable: got %0d unstable cycles want 0 (res=%h want %h)", bad, bus.result, e_r); end
    bus.div_ack = 1'b1;
    step;
    bus.div_ack = 1'b0;
  endtask

  task automatic test_reset_busy;
    logic [W-1:0] r;
    bus.div_start = 1'b1; bus.div_dividend = W'($urandom()); bus.div_divisor = W'($urandom());
    step;
    bus.div_start = 1'b0;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    #1;
    n_checks++; if (st !== ST_IDLE || {bus.sqrt_done, bus.div_done} !== 2'b00 || {bus.sqrt_ready, bus.div_ready} !== 2'b11) begin n_fail++; $display("FAIL rst_busy_idle: got st=%0d done=%b ready=%b want %0d/00/11", st, {bus.sqrt_done, bus.div_done}, {bus.sqrt_ready, bus.div_ready}, ST_IDLE); end
    r = W'($urandom());
    bus.sqrt_start = 1'b1; bus.sqrt_radicand = r;
    #1;
    n_checks++; if ({bus.core_start, bus.core_is_sqrt} !== 2'b11) begin n_fail++; $display("FAIL rst_sqrt_grant: got %b want 11", {bus.core_start, bus.core_is_sqrt}); end
    push_exp(r, '0, 1'b1);
    step;
    bus.sqrt_start = 1'b0;
    wait_done(to);
    pop_exp;
    n_checks++; if (to || bus.result !== e_r || bus.remainder !== e_m || {bus.sqrt_done, bus.div_done} !== 2'b10) begin n_fail++; $display("FAIL rst_sqrt_result: got %h/%h done=%b want %h/%h done=10", bus.result, bus.remainder, {bus.sqrt_done, bus.div_done}, e_r, e_m); end
    bus.sqrt_ack = 1'b1;
    step;
    bus.sqrt_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; spur_done = 1'b0;
    bus.div_start = 1'b0; bus.div_dividend = '0; bus.div_divisor = '0; bus.div_ack = 1'b0;
    bus.sqrt_start = 1'b0; bus.sqrt_radicand = '0; bus.sqrt_ack = 1'b0;
    test_reset;
    test_single_div;
    test_both_start;
    test_alternate;
    test_nonowner_ack;
    test_stall_hold;
    test_reset_busy;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_expected: got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_div_sqrt_arbiter.md
Name: fp_div_sqrt_arbiter

Overview:
- Shares one iterative mantissa core between the FP divide unit (requester 0) and the FP square-root unit (requester 1).
- Arbitrates start requests with round-robin priority and forwards the winner's operands and operation select to the core.
- Tracks which requester owns the core and routes the core's done/result/remainder back to the owner only.
- Holds the result until that owner acknowledges it.
- Sits between the two FP execution units and the shared core, inside the FP execution-unit group.

Parameters:
- DATA_WIDTH, 55, mantissa datapath width (FRAC_WIDTH+3 for double).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- div_start  in  1  divide request
- div_dividend  in  DATA_WIDTH  divide operand A
- div_divisor  in  DATA_WIDTH  divide operand B
- div_ready  out  1  arbiter accepts div_start this cycle
- div_done  out  1  divide result valid
- div_ack  in  1  divide result consumed
- sqrt_start  in  1  square-root request
- sqrt_radicand  in  DATA_WIDTH  square-root operand
- sqrt_ready  out  1  arbiter accepts sqrt_start this cycle
- sqrt_done  out  1  square-root result valid
- sqrt_ack  in  1  square-root result consumed
- result  out  DATA_WIDTH  shared result bus, valid with the owner's done
- remainder  out  DATA_WIDTH+2  shared remainder bus, valid with the owner's done
- core_start  out  1  single-cycle core launch
- core_is_sqrt  out  1  operation select: 0 = divide, 1 = square root
- core_a  out  DATA_WIDTH  dividend or radicand
- core_b  out  DATA_WIDTH  divisor; 0 for square root
- core_done  in  1  one-cycle core completion pulse
- core_result  in  DATA_WIDTH  core quotient or root
- core_remainder  in  DATA_WIDTH+2  core remainder

Behaviour:
- Clocking and reset: single clock clk. Reset rst is synchronous, active-high.
- Reset values: state=IDLE, owner=0, rr_ptr=0 (divide has priority), core_start=0, div_done=0, sqrt_done=0, result and remainder registers=0.
- States:
  - IDLE: core free.
  - BUSY: core iterating for owner.
  - HOLD: result registered, awaiting owner ack.
- Ready generation:
  - div_ready = sqrt_ready = (state==IDLE) | (state==HOLD & owner_ack).
  - owner_ack is the ack of the current owner. An ack from the non-owner is ignored.
- Grant:
  - In any cycle where ready is high and at least one start is asserted, exactly one requester is granted.
  - If both start, the requester selected by rr_ptr wins. rr_ptr then points to the loser.
  - If only one starts, it wins and rr_ptr points to the other requester.
  - A start that is not granted must be held by the requester. The arbiter does not queue it.
- Launch:
  - core_start, core_is_sqrt, core_a and core_b are combinational from the granted requester in the grant cycle. No added latency.
  - For sqrt, core_b=0.
  - owner is registered and the state goes to BUSY on the next edge.
- BUSY:
  - On core_done, register core_result and core_remainder, assert the owner's done, and go to HOLD.
  - Total latency from grant to done = core latency + 1 cycle.
- HOLD:
  - Only the owner's done is high. result and remainder are stable.
  - On owner_ack with no start: go to IDLE and clear done.
  - On owner_ack with a start: re-grant the same cycle, go to BUSY, and clear done.
- The non-owner's done is never asserted.
- A core_done outside BUSY is ignored. In BUSY, starts are not accepted (ready=0).
- Reset mid-operation: return to IDLE next edge. Any core iteration in flight is abandoned, and the core must accept a fresh start after reset.
- Simultaneous ack and start in HOLD from the owner itself: legal, back-to-back operation.

Test Plan:
- Reset, then div_start with dividend=0x20_0000_0000_0000, divisor=0x10_0000_0000_0000 → core_start=1, core_is_sqrt=0 the same cycle; div_ready=0 next cycle; after core_done, div_done=1 with result=core_result; sqrt_done stays 0.
- div_start and sqrt_start both asserted in the same cycle after reset → div granted first (rr_ptr=0). After div_ack, sqrt is granted in the ack cycle and launches with core_b=0 and core_is_sqrt=1.
- Both starts held continuously for four operations → grants alternate div, sqrt, div, sqrt.
- In HOLD with owner=sqrt, pulse div_ack → ignored: state stays HOLD and sqrt_done stays 1. Then sqrt_ack → IDLE.
- Stall the owner's ack for 10 cycles after core_done → result and remainder stable and done high for all 10 cycles. A spurious core_done pulse during HOLD does not change result.
- Assert rst during BUSY → next cycle state is IDLE, both done=0, both ready=1. A new sqrt_start is granted immediately.
